// File: rtl/riscv_core.sv
// riscv_core: RV32I core with a two-stage pipeline (IF, EX).
// Instructions are fetched from firmware ROM (PC[28]=0) or program ROM (PC[28]=1).
// Data RAM is word-addressed; sub-word stores do a read-modify-write in one cycle.
// Optional feature macro: RISCV_EBREAK_HALT_EN (EBREAK/ECALL halt the core until reset).
module riscv_core #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] PROG_BASE = 32'h1000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] ram_read_addr,
    output logic [31:0] ram_write_addr,
    output logic        ram_write_enable,
    output logic [31:0] ram_data_in,
    input  logic [31:0] ram_data_out,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_out,
    output logic [31:0] fw_rom_addr,
    input  logic [31:0] fw_rom_out
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpReg    = 7'b0110011;

    // Program-space selection is hard-wired to PC[28], which is where PROG_BASE sits.
    logic unused_prog_base;
    assign unused_prog_base = ^PROG_BASE;

    logic [31:0] pc;
    logic [31:0] ex_instr;
    logic [31:0] ex_pc;
    logic        ex_valid;
    logic [31:0] regs [0:31];

    logic [31:0] fetch_instr;
    logic        halt;

    // Decode fields
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;

    logic [31:0] alu_b;
    logic [31:0] alu_res;
    logic        br_cond;
    logic [31:0] eff_addr;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_val;
    logic        wb_en;
    logic [31:0] wb_data;
    logic        take;
    logic [31:0] target;
    logic [31:0] store_data;
    logic        reg_we;
    logic        redirect;

    assign rom_addr    = {4'b0000, pc[27:2], 2'b00};
    assign fw_rom_addr = {4'b0000, pc[27:2], 2'b00};
    assign fetch_instr = pc[28] ? rom_out : fw_rom_out;

    assign opcode   = ex_instr[6:0];
    assign rd       = ex_instr[11:7];
    assign funct3   = ex_instr[14:12];
    assign rs1      = ex_instr[19:15];
    assign rs2      = ex_instr[24:20];
    assign funct7b5 = ex_instr[30];

    assign imm_i = {{20{ex_instr[31]}}, ex_instr[31:20]};
    assign imm_s = {{20{ex_instr[31]}}, ex_instr[31:25], ex_instr[11:7]};
    assign imm_b = {{19{ex_instr[31]}}, ex_instr[31], ex_instr[7], ex_instr[30:25],
                    ex_instr[11:8], 1'b0};
    assign imm_u = {ex_instr[31:12], 12'h000};
    assign imm_j = {{11{ex_instr[31]}}, ex_instr[31], ex_instr[19:12], ex_instr[20],
                    ex_instr[30:21], 1'b0};

    assign rs1_val = (rs1 == 5'd0) ? 32'h0 : regs[rs1];
    assign rs2_val = (rs2 == 5'd0) ? 32'h0 : regs[rs2];

`ifdef RISCV_EBREAK_HALT_EN
    logic halted;
    logic halt_instr;

    assign halt_instr = ex_valid && ((ex_instr == 32'h0000_0073) || (ex_instr == 32'h0010_0073));
    // Freeze on the very edge the EBREAK/ECALL executes, so the following instruction never runs.
    assign halt = halted || halt_instr;

    // Sticky halt flag, cleared only by reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            halted <= 1'b0;
        end else if (halt_instr) begin
            halted <= 1'b1;
        end
    end
`else
    assign halt = 1'b0;
`endif

    // ALU shared by OP and OP-IMM; SUB exists only in the register form
    always_comb begin
        alu_b   = (opcode == OpReg) ? rs2_val : imm_i;
        alu_res = 32'h0;
        case (funct3)
            3'b000: alu_res = ((opcode == OpReg) && funct7b5) ? rs1_val - alu_b : rs1_val + alu_b;
            3'b001: alu_res = rs1_val << alu_b[4:0];
            3'b010: alu_res = {31'b0, $signed(rs1_val) < $signed(alu_b)};
            3'b011: alu_res = {31'b0, rs1_val < alu_b};
            3'b100: alu_res = rs1_val ^ alu_b;
            3'b101: alu_res = funct7b5 ? 32'($signed(rs1_val) >>> alu_b[4:0])
                                       : rs1_val >> alu_b[4:0];
            3'b110: alu_res = rs1_val | alu_b;
            default: alu_res = rs1_val & alu_b;
        endcase
    end

    // Branch comparison
    always_comb begin
        br_cond = 1'b0;
        case (funct3)
            3'b000: br_cond = (rs1_val == rs2_val);
            3'b001: br_cond = (rs1_val != rs2_val);
            3'b100: br_cond = ($signed(rs1_val) < $signed(rs2_val));
            3'b101: br_cond = ($signed(rs1_val) >= $signed(rs2_val));
            3'b110: br_cond = (rs1_val < rs2_val);
            3'b111: br_cond = (rs1_val >= rs2_val);
            default: br_cond = 1'b0;
        endcase
    end

    // Load extraction; misaligned halfwords/words stay within the aligned word
    always_comb begin
        eff_addr = rs1_val + ((opcode == OpStore) ? imm_s : imm_i);
        case (eff_addr[1:0])
            2'b00:   ld_byte = ram_data_out[7:0];
            2'b01:   ld_byte = ram_data_out[15:8];
            2'b10:   ld_byte = ram_data_out[23:16];
            default: ld_byte = ram_data_out[31:24];
        endcase
        ld_half = eff_addr[1] ? ram_data_out[31:16] : ram_data_out[15:0];
        case (funct3)
            3'b000:  ld_val = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_val = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_val = {24'h0, ld_byte};
            3'b101:  ld_val = {16'h0, ld_half};
            default: ld_val = ram_data_out;
        endcase
    end

    // Main execute decode: writeback value, control-flow target, store merge
    always_comb begin
        wb_en      = 1'b0;
        wb_data    = alu_res;
        take       = 1'b0;
        target     = ex_pc + imm_b;
        store_data = ram_data_out;
        case (opcode)
            OpLui: begin
                wb_en   = 1'b1;
                wb_data = imm_u;
            end
            OpAuipc: begin
                wb_en   = 1'b1;
                wb_data = ex_pc + imm_u;
            end
            OpJal: begin
                wb_en   = 1'b1;
                wb_data = ex_pc + 32'd4;
                take    = 1'b1;
                target  = ex_pc + imm_j;
            end
            OpJalr: begin
                wb_en   = 1'b1;
                wb_data = ex_pc + 32'd4;
                take    = 1'b1;
                target  = rs1_val + imm_i;
            end
            OpBranch: take = br_cond;
            OpLoad: begin
                wb_en   = 1'b1;
                wb_data = ld_val;
            end
            OpStore: begin
                case (funct3)
                    3'b000: begin
                        case (eff_addr[1:0])
                            2'b00:   store_data[7:0]   = rs2_val[7:0];
                            2'b01:   store_data[15:8]  = rs2_val[7:0];
                            2'b10:   store_data[23:16] = rs2_val[7:0];
                            default: store_data[31:24] = rs2_val[7:0];
                        endcase
                    end
                    3'b001: begin
                        if (eff_addr[1]) store_data[31:16] = rs2_val[15:0];
                        else             store_data[15:0]  = rs2_val[15:0];
                    end
                    default: store_data = rs2_val;
                endcase
            end
            OpImm, OpReg: wb_en = 1'b1;
            default: wb_en = 1'b0;
        endcase
    end

    assign reg_we   = ex_valid && !halt && wb_en && (rd != 5'd0);
    assign redirect = ex_valid && !halt && take;

    assign ram_read_addr    = {2'b00, eff_addr[31:2]};
    assign ram_write_addr   = {2'b00, eff_addr[31:2]};
    assign ram_data_in      = store_data;
    assign ram_write_enable = rst_n && ex_valid && !halt && (opcode == OpStore);

    // PC and IF/EX register; a taken redirect squashes the fetched instruction
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc       <= RESET_PC;
            ex_instr <= NOP;
            ex_pc    <= 32'h0;
            ex_valid <= 1'b0;
        end else if (!halt) begin
            ex_pc <= pc;
            if (redirect) begin
                pc       <= {target[31:2], 2'b00};
                ex_instr <= NOP;
                ex_valid <= 1'b0;
            end else begin
                pc       <= pc + 32'd4;
                ex_instr <= fetch_instr;
                ex_valid <= 1'b1;
            end
        end
    end

    // Register file writeback; x0 is never written
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= 32'h0;
            end
        end else if (reg_we) begin
            regs[rd] <= wb_data;
        end
    end

endmodule

// File: tb/tb_riscv_core.sv
// Bench for riscv_core: ROM/RAM models, directed firmware/program, store-log checking.
// Register results are exposed by storing them to RAM and checking the store log.
module tb_riscv_core;

    logic        clk;
    logic        rst_n;
    logic [31:0] ram_read_addr;
    logic [31:0] ram_write_addr;
    logic        ram_write_enable;
    logic [31:0] ram_data_in;
    logic [31:0] ram_data_out;
    logic [31:0] rom_addr;
    logic [31:0] rom_out;
    logic [31:0] fw_rom_addr;
    logic [31:0] fw_rom_out;

    logic [31:0] fw   [0:63];
    logic [31:0] prog [0:63];
    logic [31:0] ram  [0:63];

    logic [31:0] st_addr [$];
    logic [31:0] st_data [$];

    int checks;
    int errors;

    riscv_core dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .ram_read_addr    (ram_read_addr),
        .ram_write_addr   (ram_write_addr),
        .ram_write_enable (ram_write_enable),
        .ram_data_in      (ram_data_in),
        .ram_data_out     (ram_data_out),
        .rom_addr         (rom_addr),
        .rom_out          (rom_out),
        .fw_rom_addr      (fw_rom_addr),
        .fw_rom_out       (fw_rom_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign fw_rom_out   = fw[fw_rom_addr[7:2]];
    assign rom_out      = prog[rom_addr[7:2]];
    assign ram_data_out = ram[ram_read_addr[5:0]];

    always @(posedge clk) begin
        if (rst_n && ram_write_enable) begin
            st_addr.push_back(ram_write_addr);
            st_data.push_back(ram_data_in);
            ram[ram_write_addr[5:0]] <= ram_data_in;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction

    localparam logic [6:0] OI = 7'b0010011;

`ifdef RISCV_EBREAK_HALT_EN
    localparam int NStores = 14;
`else
    localparam int NStores = 15;
`endif

    logic [31:0] exp_addr [0:14];
    logic [31:0] exp_data [0:14];

    initial begin
        for (int i = 0; i < 64; i++) begin
            fw[i]   = 32'h0000_0013;
            prog[i] = 32'h0000_0013;
            ram[i]  = 32'h0;
        end
        ram[1] = 32'h8000_00FF;

        // Firmware
        fw[0]  = enc_i(12'd5, 5'd0, 3'b000, 5'd1, OI);            // ADDI x1,x0,5
        fw[1]  = enc_i(12'hFFD, 5'd0, 3'b000, 5'd2, OI);          // ADDI x2,x0,-3
        fw[2]  = enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd3);          // ADD x3,x1,x2
        fw[3]  = enc_r(7'h00, 5'd2, 5'd1, 3'b011, 5'd4);          // SLTU x4,x1,x2
        fw[4]  = enc_s(12'd8, 5'd3, 5'd0, 3'b010);                // SW x3,8(x0)
        fw[5]  = enc_s(12'd12, 5'd4, 5'd0, 3'b010);               // SW x4,12(x0)
        fw[6]  = {20'h10000, 5'd5, 7'b0110111};                   // LUI x5,0x10000
        fw[7]  = enc_i(12'd0, 5'd5, 3'b000, 5'd0, 7'b1100111);    // JALR x0,0(x5)
        fw[8]  = enc_i(12'd99, 5'd0, 3'b000, 5'd10, OI);          // ADDI x10,x0,99 (squashed)

        // Program ROM
        prog[0]  = enc_s(12'd16, 5'd10, 5'd0, 3'b010);            // SW x10,16(x0)
        prog[1]  = enc_b(13'd8, 5'd0, 5'd0, 3'b000);              // BEQ x0,x0,+8 (taken)
        prog[2]  = enc_i(12'd1, 5'd0, 3'b000, 5'd6, OI);          // ADDI x6,x0,1 (skipped)
        prog[3]  = enc_s(12'd20, 5'd6, 5'd0, 3'b010);             // SW x6,20(x0)
        prog[4]  = enc_b(13'd8, 5'd0, 5'd1, 3'b000);              // BEQ x1,x0,+8 (not taken)
        prog[5]  = enc_i(12'd1, 5'd0, 3'b000, 5'd6, OI);          // ADDI x6,x0,1
        prog[6]  = enc_s(12'd24, 5'd6, 5'd0, 3'b010);             // SW x6,24(x0)
        prog[7]  = enc_i(12'd4, 5'd0, 3'b000, 5'd7, 7'b0000011);  // LB x7,4(x0)
        prog[8]  = enc_i(12'd7, 5'd0, 3'b100, 5'd8, 7'b0000011);  // LBU x8,7(x0)
        prog[9]  = enc_s(12'd28, 5'd7, 5'd0, 3'b010);             // SW x7,28(x0)
        prog[10] = enc_s(12'd32, 5'd8, 5'd0, 3'b010);             // SW x8,32(x0)
        prog[11] = enc_s(12'd5, 5'd1, 5'd0, 3'b000);              // SB x1,5(x0)
        prog[12] = enc_i(12'd6, 5'd0, 3'b001, 5'd11, 7'b0000011); // LH x11,6(x0)
        prog[13] = enc_s(12'd36, 5'd11, 5'd0, 3'b010);            // SW x11,36(x0)
        prog[14] = enc_i(12'h404, 5'd11, 3'b101, 5'd12, OI);      // SRAI x12,x11,4
        prog[15] = enc_s(12'd40, 5'd12, 5'd0, 3'b010);            // SW x12,40(x0)
        prog[16] = enc_j(21'd8, 5'd13);                           // JAL x13,+8
        prog[17] = enc_i(12'd0, 5'd0, 3'b000, 5'd13, OI);         // ADDI x13,x0,0 (squashed)
        prog[18] = enc_s(12'd44, 5'd13, 5'd0, 3'b010);            // SW x13,44(x0)
        prog[19] = enc_s(12'd2, 5'd2, 5'd0, 3'b001);              // SH x2,2(x0)
        prog[20] = {20'h00001, 5'd14, 7'b0010111};                // AUIPC x14,1
        prog[21] = enc_s(12'd48, 5'd14, 5'd0, 3'b010);            // SW x14,48(x0)
        prog[22] = enc_r(7'h20, 5'd2, 5'd1, 3'b000, 5'd15);       // SUB x15,x1,x2
        prog[23] = enc_r(7'h00, 5'd15, 5'd1, 3'b001, 5'd16);      // SLL x16,x1,x15
        prog[24] = enc_s(12'd52, 5'd16, 5'd0, 3'b010);            // SW x16,52(x0)
        prog[25] = 32'h0010_0073;                                 // EBREAK
        prog[26] = enc_i(12'd7, 5'd0, 3'b000, 5'd9, OI);          // ADDI x9,x0,7
        prog[27] = enc_s(12'd56, 5'd9, 5'd0, 3'b010);             // SW x9,56(x0)
        prog[28] = enc_j(21'd0, 5'd0);                            // JAL x0,0

        // Hand-computed store log
        exp_addr[0]  = 32'd2;  exp_data[0]  = 32'h0000_0002;  // x3 = 5 + -3
        exp_addr[1]  = 32'd3;  exp_data[1]  = 32'h0000_0001;  // SLTU 5 < 0xFFFFFFFD
        exp_addr[2]  = 32'd4;  exp_data[2]  = 32'h0000_0000;  // squashed ADDI after JALR
        exp_addr[3]  = 32'd5;  exp_data[3]  = 32'h0000_0000;  // taken BEQ skipped ADDI
        exp_addr[4]  = 32'd6;  exp_data[4]  = 32'h0000_0001;  // not-taken BEQ
        exp_addr[5]  = 32'd7;  exp_data[5]  = 32'hFFFF_FFFF;  // LB of 0xFF
        exp_addr[6]  = 32'd8;  exp_data[6]  = 32'h0000_0080;  // LBU of 0x80
        exp_addr[7]  = 32'd1;  exp_data[7]  = 32'h8000_05FF;  // SB merge
        exp_addr[8]  = 32'd9;  exp_data[8]  = 32'hFFFF_8000;  // LH upper half
        exp_addr[9]  = 32'd10; exp_data[9]  = 32'hFFFF_F800;  // SRAI sign fill
        exp_addr[10] = 32'd11; exp_data[10] = 32'h1000_0044;  // JAL link
        exp_addr[11] = 32'd0;  exp_data[11] = 32'hFFFD_0000;  // SH upper half merge
        exp_addr[12] = 32'd12; exp_data[12] = 32'h1000_1050;  // AUIPC
        exp_addr[13] = 32'd13; exp_data[13] = 32'h0000_0500;  // 5 << (5 - -3)
        exp_addr[14] = 32'd14; exp_data[14] = 32'h0000_0007;  // ADDI after EBREAK (no halt)
    end

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;

        @(negedge clk);
        check_eq("reset_we_0", {31'b0, ram_write_enable}, 32'h0);
        @(negedge clk);
        check_eq("reset_we_1", {31'b0, ram_write_enable}, 32'h0);
        rst_n = 1'b1;
        check_eq("fetch_0", fw_rom_addr, 32'h0);
        @(posedge clk); #1;
        check_eq("fetch_4", fw_rom_addr, 32'h4);
        @(posedge clk); #1;
        check_eq("fetch_8", fw_rom_addr, 32'h8);

        repeat (200) @(posedge clk);
        #1;

        check_eq("store_count", 32'(st_addr.size()), 32'(NStores));
        for (int i = 0; i < NStores; i++) begin
            logic [31:0] ga;
            logic [31:0] gd;
            ga = (i < st_addr.size()) ? st_addr[i] : 32'hDEAD_BEEF;
            gd = (i < st_data.size()) ? st_data[i] : 32'hDEAD_BEEF;
            check_eq($sformatf("store_addr_%0d", i), ga, exp_addr[i]);
            check_eq($sformatf("store_data_%0d", i), gd, exp_data[i]);
        end
        check_eq("ram_word1", ram[1], 32'h8000_05FF);

`ifdef RISCV_EBREAK_HALT_EN
        // Halted with PC on the instruction after EBREAK
        check_eq("halt_pc_a", rom_addr, 32'h0000_0068);
        check_eq("halt_we_a", {31'b0, ram_write_enable}, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        check_eq("halt_pc_b", rom_addr, 32'h0000_0068);
        check_eq("halt_fw_b", fw_rom_addr, 32'h0000_0068);
`else
        check_eq("ram_word14", ram[14], 32'h0000_0007);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
